// File: rtl/ipsxb_qsgmii_pkg.sv
// Shared constants, FSM state encoding and width helper for the QSGMII
// receive lane aligner.
package ipsxb_qsgmii_pkg;

    // Comma characters: K28.1 marks the port-0 lane, K28.5 is the ordinary comma.
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    // Ceiling log2, usable in constant (parameter) expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ipsxb_qsgmii_lane_rot_v1_1.sv
// Combinational lane rotator: port p takes lane (offset + p) of the
// two-word window {current word, previous word}, previous word in the low lanes.
module ipsxb_qsgmii_lane_rot_v1_1
    import ipsxb_qsgmii_pkg::*;
#(
    parameter  int CH_NUM = 4,
    localparam int OFF_W  = clog2(CH_NUM)
) (
    input  logic [8*CH_NUM-1:0] cur_rxd,
    input  logic [CH_NUM-1:0]   cur_rxk,
    input  logic [8*CH_NUM-1:0] d1_rxd,
    input  logic [CH_NUM-1:0]   d1_rxk,
    input  logic [OFF_W-1:0]    offset,
    output logic [8*CH_NUM-1:0] rot_rxd,
    output logic [CH_NUM-1:0]   rot_rxk
);

    logic [16*CH_NUM-1:0] cat_rxd;
    logic [2*CH_NUM-1:0]  cat_rxk;

    assign cat_rxd = {cur_rxd, d1_rxd};
    assign cat_rxk = {cur_rxk, d1_rxk};

    // Select the CH_NUM-lane window starting at the offset lane; every offset
    // gets its own constant-index slice so the mux stays a plain case tree.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path would infer a latch.
        rot_rxd = '0;
        rot_rxk = '0;
        for (int o = 0; o < CH_NUM; o++) begin
            if (offset == OFF_W'(o)) begin
                for (int p = 0; p < CH_NUM; p++) begin
                    rot_rxd[8*p +: 8] = cat_rxd[8*(o+p) +: 8];
                    rot_rxk[p]        = cat_rxk[o+p];
                end
            end
        end
    end

endmodule

// File: rtl/ipsxb_qsgmii_pcs_rx_align_v1_1.sv
// QSGMII receive lane aligner: finds the lane carrying port 0 via K28.1,
// locks onto it with hysteresis and rotates each word so port p sits at
// bits [8p+7:8p].
module ipsxb_qsgmii_pcs_rx_align_v1_1
    import ipsxb_qsgmii_pkg::*;
#(
    parameter  int CH_NUM     = 4,
    parameter  int LOCK_CNT   = 3,
    parameter  int UNLOCK_CNT = 7,
    localparam int OFF_W      = clog2(CH_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8*CH_NUM-1:0] pcs_rxd,
    input  logic [CH_NUM-1:0]   pcs_rxk,
    output logic [8*CH_NUM-1:0] p_rxd_out,
    output logic [CH_NUM-1:0]   p_rxk_out,
    output logic                lock,
    output logic [OFF_W-1:0]    lane_offset,
    output logic [7:0]          relock_cnt
);

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    align_state_e          state_q, state_d;
    logic [OFF_W-1:0]      cand_q, cand_d;
    logic [3:0]            match_cnt_q, match_cnt_d;
    logic [3:0]            miss_cnt_q, miss_cnt_d;
    logic [OFF_W-1:0]      lane_offset_q, lane_offset_d;
    logic                  lock_q, lock_d;
    logic [7:0]            relock_cnt_q, relock_cnt_d;
    logic [8*CH_NUM-1:0]   d1_rxd_q, d1_rxd_d;
    logic [CH_NUM-1:0]     d1_rxk_q, d1_rxk_d;
    logic [8*CH_NUM-1:0]   rxd_out_q, rxd_out_d;
    logic [CH_NUM-1:0]     rxk_out_q, rxk_out_d;

    logic [CH_NUM-1:0]     hit;
    logic                  hit_any;
    logic                  hit_single;
    logic [OFF_W-1:0]      hit_lane;
    logic [8*CH_NUM-1:0]   rot_rxd;
    logic [CH_NUM-1:0]     rot_rxk;

    // K28.1 detection on the live word; hit_lane is meaningful only when a
    // single lane hits.
    always_comb begin
        hit      = '0;
        hit_lane = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            hit[i] = pcs_rxk[i] && (pcs_rxd[8*i +: 8] == K28_1);
            if (hit[i]) begin
                hit_lane = OFF_W'(i);
            end
        end
        hit_any    = |hit;
        hit_single = hit_any && ((hit & (hit - CH_NUM'(1))) == '0);
    end

    ipsxb_qsgmii_lane_rot_v1_1 #(
        .CH_NUM (CH_NUM)
    ) u_lane_rot (
        .cur_rxd (pcs_rxd),
        .cur_rxk (pcs_rxk),
        .d1_rxd  (d1_rxd_q),
        .d1_rxk  (d1_rxk_q),
        .offset  (lane_offset_q),
        .rot_rxd (rot_rxd),
        .rot_rxk (rot_rxk)
    );

    // Alignment FSM next state and counters; no-hit cycles never move anything.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        lane_offset_d = lane_offset_q;
        relock_cnt_d  = relock_cnt_q;
        unique case (state_q)
            HUNT: begin
                if (hit_single) begin
                    cand_d = hit_lane;
                    if (LOCK_TGT == 4'd1) begin
                        state_d       = LOCKED;
                        lane_offset_d = hit_lane;
                        match_cnt_d   = '0;
                        miss_cnt_d    = '0;
                    end else begin
                        state_d     = VERIFY;
                        match_cnt_d = 4'd1;
                    end
                end
            end
            VERIFY: begin
                if (hit_any) begin
                    if (hit_single && (hit_lane == cand_q)) begin
                        if (match_cnt_q + 4'd1 == LOCK_TGT) begin
                            state_d       = LOCKED;
                            lane_offset_d = cand_q;
                            match_cnt_d   = '0;
                            miss_cnt_d    = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d     = HUNT;
                        match_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (hit_any) begin
                    if (hit_single && (hit_lane == lane_offset_q)) begin
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q + 4'd1 == UNLOCK_TGT) begin
                        state_d    = HUNT;
                        miss_cnt_d = '0;
                        if (relock_cnt_q != 8'hFF) begin
                            relock_cnt_d = relock_cnt_q + 8'd1;
                        end
                    end else begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
        lock_d = (state_d == LOCKED);
    end

    // Datapath next values: delay line and rotated output word.
    always_comb begin
        d1_rxd_d  = pcs_rxd;
        d1_rxk_d  = pcs_rxk;
        rxd_out_d = rot_rxd;
        rxk_out_d = rot_rxk;
    end

    // State, counters and datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            cand_q        <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            lane_offset_q <= '0;
            lock_q        <= 1'b0;
            relock_cnt_q  <= '0;
            d1_rxd_q      <= '0;
            d1_rxk_q      <= '0;
            rxd_out_q     <= '0;
            rxk_out_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            cand_q        <= cand_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            lane_offset_q <= lane_offset_d;
            lock_q        <= lock_d;
            relock_cnt_q  <= relock_cnt_d;
            d1_rxd_q      <= d1_rxd_d;
            d1_rxk_q      <= d1_rxk_d;
            rxd_out_q     <= rxd_out_d;
            rxk_out_q     <= rxk_out_d;
        end
    end

    assign p_rxd_out   = rxd_out_q;
    assign p_rxk_out   = rxk_out_q;
    assign lock        = lock_q;
    assign lane_offset = lane_offset_q;
    assign relock_cnt  = relock_cnt_q;

endmodule

// File: tb/tb_ipsxb_qsgmii_pcs_rx_align_v1_1.sv
// Directed bench for the QSGMII receive lane aligner: a 4-lane instance for
// the FSM scenarios and an 8-lane instance for the rotation stream.
module tb_ipsxb_qsgmii_pcs_rx_align_v1_1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic [31:0] rxd4 = '0;
    logic [3:0]  rxk4 = '0;
    logic [31:0] out4_d;
    logic [3:0]  out4_k;
    logic        lock4;
    logic [1:0]  off4;
    logic [7:0]  relock4;

    logic [63:0] rxd8 = '0;
    logic [7:0]  rxk8 = '0;
    logic [63:0] out8_d;
    logic [7:0]  out8_k;
    logic        lock8;
    logic [2:0]  off8;
    logic [7:0]  relock8;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ipsxb_qsgmii_pcs_rx_align_v1_1 #(.CH_NUM(4), .LOCK_CNT(3), .UNLOCK_CNT(7)) dut4 (
        .clk (clk), .rst_n (rst_n), .pcs_rxd (rxd4), .pcs_rxk (rxk4),
        .p_rxd_out (out4_d), .p_rxk_out (out4_k), .lock (lock4),
        .lane_offset (off4), .relock_cnt (relock4)
    );

    ipsxb_qsgmii_pcs_rx_align_v1_1 #(.CH_NUM(8), .LOCK_CNT(3), .UNLOCK_CNT(7)) dut8 (
        .clk (clk), .rst_n (rst_n), .pcs_rxd (rxd8), .pcs_rxk (rxk8),
        .p_rxd_out (out8_d), .p_rxk_out (out8_k), .lock (lock8),
        .lane_offset (off8), .relock_cnt (relock8)
    );

    // Present one word and return at the following falling edge, i.e. after
    // the rising edge that consumed it.
    task automatic send4(input logic [31:0] d, input logic [3:0] k);
        rxd4 = d;
        rxk4 = k;
        @(negedge clk);
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) send4(32'h5A5A5A5A, 4'b0000);
    endtask

    task automatic send8(input logic [63:0] d, input logic [7:0] k);
        rxd8 = d;
        rxk8 = k;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL reset_lock: got %0b want 0", lock4); end
        tests_run++; if (off4 !== 2'd0) begin tests_failed++; $display("FAIL reset_offset: got %0d want 0", off4); end
        tests_run++; if (relock4 !== 8'd0) begin tests_failed++; $display("FAIL reset_relock: got %0d want 0", relock4); end
        tests_run++; if ({out4_d, out4_k} !== 36'd0) begin tests_failed++; $display("FAIL reset_out: got %h/%b want 0", out4_d, out4_k); end
        tests_run++; if ({lock8, off8, out8_d} !== 68'd0) begin tests_failed++; $display("FAIL reset_dut8: got %0b %0d %h want 0", lock8, off8, out8_d); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // K28.1 on lane 2 every 16 words; lock on the 3rd sighting, port 0 aligned.
    task automatic test_lock;
        for (int g = 0; g < 3; g++) begin
            send4(32'h443C2211, 4'b0100);
            if (g < 2) begin
                tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL lock_early%0d: got %0b want 0", g, lock4); end
            end else begin
                tests_run++; if (lock4 !== 1'b1) begin tests_failed++; $display("FAIL lock_rise: got %0b want 1", lock4); end
                tests_run++; if (off4 !== 2'd2) begin tests_failed++; $display("FAIL lock_offset: got %0d want 2", off4); end
            end
            send4(32'h88776655, 4'b0000);
            if (g < 2) begin
                tests_run++; if ({out4_d, out4_k} !== {32'h443C2211, 4'b0100}) begin tests_failed++; $display("FAIL out_unrot%0d: got %h/%b want 443c2211/0100", g, out4_d, out4_k); end
            end else begin
                tests_run++; if ({out4_d, out4_k} !== {32'h6655443C, 4'b0001}) begin tests_failed++; $display("FAIL out_rot: got %h/%b want 6655443c/0001", out4_d, out4_k); end
            end
            idle4(14);
        end
    endtask

    // Six misses at lane 1 are tolerated, one good sighting clears the count.
    task automatic test_hold;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                send4(32'h77663C55, 4'b0010);
                idle4(3);
            end
            tests_run++; if (lock4 !== 1'b1) begin tests_failed++; $display("FAIL hold_after_6miss%0d: got %0b want 1", r, lock4); end
            send4(32'h443C2211, 4'b0100);
            idle4(3);
            tests_run++; if (lock4 !== 1'b1) begin tests_failed++; $display("FAIL hold_after_good%0d: got %0b want 1", r, lock4); end
        end
        tests_run++; if (relock4 !== 8'd0) begin tests_failed++; $display("FAIL hold_relock: got %0d want 0", relock4); end
    endtask

    // Seven K28.1 at lane 0 unlock; three more relock at offset 0.
    task automatic test_unlock;
        for (int i = 1; i <= 7; i++) begin
            send4(32'h7766553C, 4'b0001);
            if (i == 6) begin
                tests_run++; if (lock4 !== 1'b1) begin tests_failed++; $display("FAIL unlock_6th: got %0b want 1", lock4); end
            end
            if (i == 7) begin
                tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL unlock_7th: got %0b want 0", lock4); end
                tests_run++; if (relock4 !== 8'd1) begin tests_failed++; $display("FAIL unlock_relock: got %0d want 1", relock4); end
                tests_run++; if (off4 !== 2'd2) begin tests_failed++; $display("FAIL unlock_offset_held: got %0d want 2", off4); end
            end
            idle4(2);
        end
        for (int i = 1; i <= 3; i++) begin
            send4(32'h7766553C, 4'b0001);
            if (i < 3) begin
                tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL relock_early%0d: got %0b want 0", i, lock4); end
            end
        end
        tests_run++; if ({lock4, off4} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL relock: got lock %0b off %0d want 1/0", lock4, off4); end
        send4(32'h88776655, 4'b0000);
        tests_run++; if ({out4_d, out4_k} !== {32'h7766553C, 4'b0001}) begin tests_failed++; $display("FAIL relock_out: got %h/%b want 7766553c/0001", out4_d, out4_k); end
        idle4(3);
    endtask

    // Multi-lane K28.1 words: ignored in HUNT, abort VERIFY.
    task automatic test_multi;
        for (int i = 0; i < 7; i++) send4(32'h77663C55, 4'b0010);
        tests_run++; if ({lock4, relock4} !== {1'b0, 8'd2}) begin tests_failed++; $display("FAIL multi_unlock: got %0b/%0d want 0/2", lock4, relock4); end
        send4(32'h3C00003C, 4'b1001);
        send4(32'h3C221100, 4'b1000);
        send4(32'h3C221100, 4'b1000);
        tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL multi_hunt_2nd: got %0b want 0", lock4); end
        send4(32'h3C221100, 4'b1000);
        tests_run++; if ({lock4, off4} !== {1'b1, 2'd3}) begin tests_failed++; $display("FAIL multi_hunt_lock: got %0b/%0d want 1/3", lock4, off4); end
        for (int i = 0; i < 7; i++) send4(32'h7766553C, 4'b0001);
        tests_run++; if ({lock4, relock4} !== {1'b0, 8'd3}) begin tests_failed++; $display("FAIL multi_unlock2: got %0b/%0d want 0/3", lock4, relock4); end
        send4(32'h77663C55, 4'b0010);
        idle4(1);
        send4(32'h77663C55, 4'b0010);
        send4(32'h3C00003C, 4'b1001);
        send4(32'h77663C55, 4'b0010);
        tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL multi_verify_abort: got %0b want 0", lock4); end
        send4(32'h77663C55, 4'b0010);
        tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL multi_verify_2nd: got %0b want 0", lock4); end
        send4(32'h77663C55, 4'b0010);
        tests_run++; if ({lock4, off4} !== {1'b1, 2'd1}) begin tests_failed++; $display("FAIL multi_verify_lock: got %0b/%0d want 1/1", lock4, off4); end
        idle4(3);
    endtask

    // Asynchronous reset while locked, then a fresh three-sighting relock.
    task automatic test_reset_mid;
        rxd4 = 32'h5A5A5A5A;
        rxk4 = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if ({lock4, off4, relock4} !== 11'd0) begin tests_failed++; $display("FAIL midreset_ctrl: got %0b/%0d/%0d want 0/0/0", lock4, off4, relock4); end
        tests_run++; if ({out4_d, out4_k} !== 36'd0) begin tests_failed++; $display("FAIL midreset_out: got %h/%b want 0", out4_d, out4_k); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send4(32'h443C2211, 4'b0100);
            idle4(2);
            if (i < 3) begin
                tests_run++; if (lock4 !== 1'b0) begin tests_failed++; $display("FAIL midreset_early%0d: got %0b want 0", i, lock4); end
            end
        end
        tests_run++; if ({lock4, off4, relock4} !== {1'b1, 2'd2, 8'd0}) begin tests_failed++; $display("FAIL midreset_relock: got %0b/%0d/%0d want 1/2/0", lock4, off4, relock4); end
    endtask

    // 8-lane instance locked at offset 5 with an incrementing byte stream;
    // each output word must read n..n+7 across the rotation and byte wrap.
    task automatic test_rot8;
        logic [63:0] w;
        logic [63:0] e;
        rxd4 = '0;
        rxk4 = '0;
        for (int i = 0; i < 3; i++) send8(64'h0000_3C00_0000_0000, 8'b0010_0000);
        tests_run++; if ({lock8, off8} !== {1'b1, 3'd5}) begin tests_failed++; $display("FAIL rot8_lock: got %0b/%0d want 1/5", lock8, off8); end
        for (int n = 0; n <= 32; n++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(8*n + i);
            send8(w, 8'h00);
            if (n >= 1) begin
                for (int p = 0; p < 8; p++) e[8*p +: 8] = 8'(8*(n-1) + 5 + p);
                tests_run++; if ({out8_d, out8_k} !== {e, 8'h00}) begin tests_failed++; $display("FAIL rot8_word%0d: got %h/%h want %h/00", n, out8_d, out8_k, e); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_hold;
        test_unlock;
        test_multi;
        test_reset_mid;
        test_rot8;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "timeout");
    end

endmodule
